// File: rtl/id_sequence_checker.sv
// id_sequence_checker
//   Watches a stream of BCD digits and checks it against the fixed 9-digit
//   ID 5,0,1,1,7,0,1,3,8. A complete ID raises a one-cycle id_ok pulse. A
//   wrong digit raises a one-cycle seq_err pulse and resyncs the checker on
//   the leading digit. Both pulses are registered and appear one cycle after
//   the deciding digit is sampled.
//
// Parameters
//   CNT_W        width of match_count / err_count (4..16)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   digit_in     received digit, qualified by digit_valid
//   digit_valid  digit_in is valid this cycle (always accepted)
//   exp_idx      registered index 0..8 of the next expected digit
//   exp_digit    combinational expected digit at exp_idx (4'hF if illegal)
//   id_ok        one-cycle pulse: complete ID received
//   seq_err      one-cycle pulse: accepted digit mismatched
//   match_count  saturating count of complete IDs
//   err_count    saturating count of mismatches when CHECKER_ERR_COUNT_EN
//                is defined, constant 0 otherwise
//
// Build option
//   CHECKER_ERR_COUNT_EN  define to build the mismatch counter
module id_sequence_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  output logic [3:0]       exp_idx,
  output logic [3:0]       exp_digit,
  output logic             id_ok,
  output logic             seq_err,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0] LAST_IDX   = 4'd8;
  localparam logic [3:0] LEAD_DIGIT = 4'd5;

  logic [3:0]       idx_q, idx_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] mc_q, mc_d;

  // Expected digit decode; unreachable indices decode to 4'hF.
  always_comb begin
    exp_digit = 4'hF;
    unique case (idx_q)
      4'd0:    exp_digit = 4'd5;
      4'd1:    exp_digit = 4'd0;
      4'd2:    exp_digit = 4'd1;
      4'd3:    exp_digit = 4'd1;
      4'd4:    exp_digit = 4'd7;
      4'd5:    exp_digit = 4'd0;
      4'd6:    exp_digit = 4'd1;
      4'd7:    exp_digit = 4'd3;
      4'd8:    exp_digit = 4'd8;
      default: exp_digit = 4'hF;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    ok_d  = 1'b0;
    err_d = 1'b0;
    mc_d  = mc_q;
    if (idx_q > LAST_IDX) begin
      // An out-of-range index realigns to the start of the ID.
      idx_d = '0;
    end else if (digit_valid) begin
      if (digit_in == exp_digit) begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          ok_d  = 1'b1;
          if (mc_q != '1) mc_d = mc_q + CNT_W'(1);
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        err_d = 1'b1;
        // A mismatching 5 is itself a valid start of a new ID.
        idx_d = (digit_in == LEAD_DIGIT) ? 4'd1 : 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      mc_q  <= '0;
    end else begin
      idx_q <= idx_d;
      ok_q  <= ok_d;
      err_q <= err_d;
      mc_q  <= mc_d;
    end
  end

`ifdef CHECKER_ERR_COUNT_EN
  logic [CNT_W-1:0] ec_q, ec_d;

  always_comb begin
    ec_d = ec_q;
    if (err_d && (ec_q != '1)) ec_d = ec_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ec_q <= '0;
    else        ec_q <= ec_d;
  end

  assign err_count = ec_q;
`else
  assign err_count = '0;
`endif

  assign exp_idx     = idx_q;
  assign id_ok       = ok_q;
  assign seq_err     = err_q;
  assign match_count = mc_q;

endmodule

// File: tb/tb_id_sequence_checker.sv
// Testbench for id_sequence_checker: table-driven vectors with a scoreboard
// queue, plus hand-written sequences for random gaps, asynchronous reset
// and counter saturation (second instance with CNT_W=4).
module tb_id_sequence_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic [3:0] exp_idx;
  logic [3:0] exp_digit;
  logic       id_ok;
  logic       seq_err;
  logic [7:0] match_count;
  logic [7:0] err_count;

  logic [3:0] s_digit_in;
  logic       s_digit_valid;
  logic [3:0] s_exp_idx;
  logic [3:0] s_exp_digit;
  logic       s_id_ok;
  logic       s_seq_err;
  logic [3:0] s_match_count;
  logic [3:0] s_err_count;

  id_sequence_checker #(.CNT_W(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .exp_idx     (exp_idx),
    .exp_digit   (exp_digit),
    .id_ok       (id_ok),
    .seq_err     (seq_err),
    .match_count (match_count),
    .err_count   (err_count)
  );

  id_sequence_checker #(.CNT_W(4)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (s_digit_in),
    .digit_valid (s_digit_valid),
    .exp_idx     (s_exp_idx),
    .exp_digit   (s_exp_digit),
    .id_ok       (s_id_ok),
    .seq_err     (s_seq_err),
    .match_count (s_match_count),
    .err_count   (s_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       v;
    logic [3:0] idx;
    logic       ok;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic       ok;
    logic       err;
    logic [7:0] mc;
    logic [7:0] ec;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [3:0] ref_seq [0:8];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [3:0] m_idx;
  logic [7:0] m_mc;
  logic [7:0] m_ec;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic add(input int d, input bit v, input int idx, input bit ok, input bit err);
    vec_t t;
    t.d = 4'(d); t.v = v; t.idx = 4'(idx); t.ok = ok; t.err = err;
    vecs.push_back(t);
  endtask

  // Drive one cycle on the main DUT, push the expectation, compare after the edge.
  task automatic apply(input logic [3:0] d, input logic v, input logic [3:0] idx,
                       input logic ok, input logic err);
    exp_t e;
    exp_t g;
    @(negedge clk);
    digit_in    = d;
    digit_valid = v;
    #1;
    chk("exp_digit", int'(exp_digit), int'(ref_seq[m_idx]));
    if (ok && m_mc != 8'hFF) m_mc = m_mc + 8'd1;
`ifdef CHECKER_ERR_COUNT_EN
    if (err && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
`endif
    m_idx = idx;
    e.idx = idx; e.ok = ok; e.err = err; e.mc = m_mc; e.ec = m_ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      chk("exp_idx", int'(exp_idx), int'(g.idx));
      chk("id_ok", int'(id_ok), int'(g.ok));
      chk("seq_err", int'(seq_err), int'(g.err));
      chk("match_count", int'(match_count), int'(g.mc));
      chk("err_count", int'(err_count), int'(g.ec));
    end
  endtask

  task automatic apply_id();
    for (int k = 0; k < 9; k++)
      apply(ref_seq[k], 1'b1, 4'((k + 1) % 9), k == 8, 1'b0);
  endtask

  initial begin
    ref_seq[0] = 4'd5; ref_seq[1] = 4'd0; ref_seq[2] = 4'd1;
    ref_seq[3] = 4'd1; ref_seq[4] = 4'd7; ref_seq[5] = 4'd0;
    ref_seq[6] = 4'd1; ref_seq[7] = 4'd3; ref_seq[8] = 4'd8;

    // idle cycle holds index 0
    add(5, 0, 0, 0, 0);
    // full ID
    add(5, 1, 1, 0, 0); add(0, 1, 2, 0, 0); add(1, 1, 3, 0, 0);
    add(1, 1, 4, 0, 0); add(7, 1, 5, 0, 0); add(0, 1, 6, 0, 0);
    add(1, 1, 7, 0, 0); add(3, 1, 8, 0, 0); add(8, 1, 0, 1, 0);
    // 5,0,1,9 -> mismatch, back to 0
    add(5, 1, 1, 0, 0); add(0, 1, 2, 0, 0); add(1, 1, 3, 0, 0);
    add(9, 1, 0, 0, 1);
    // misaligned start at index 0
    add(3, 1, 0, 0, 1);
    // 5,0,5 -> second 5 resyncs to index 1, then finish the ID with a gap
    add(5, 1, 1, 0, 0); add(0, 1, 2, 0, 0); add(5, 1, 1, 0, 1);
    add(0, 1, 2, 0, 0); add(1, 1, 3, 0, 0); add(7, 0, 3, 0, 0);
    add(1, 1, 4, 0, 0); add(7, 1, 5, 0, 0); add(0, 1, 6, 0, 0);
    add(1, 1, 7, 0, 0); add(3, 1, 8, 0, 0); add(8, 1, 0, 1, 0);
    // two IDs back-to-back, no idle cycle
    for (int r = 0; r < 2; r++) begin
      add(5, 1, 1, 0, 0); add(0, 1, 2, 0, 0); add(1, 1, 3, 0, 0);
      add(1, 1, 4, 0, 0); add(7, 1, 5, 0, 0); add(0, 1, 6, 0, 0);
      add(1, 1, 7, 0, 0); add(3, 1, 8, 0, 0); add(8, 1, 0, 1, 0);
    end
    // mismatch at the last digit (5 resyncs), then non-5 mismatch at index 2
    add(5, 1, 1, 0, 0); add(0, 1, 2, 0, 0); add(1, 1, 3, 0, 0);
    add(1, 1, 4, 0, 0); add(7, 1, 5, 0, 0); add(0, 1, 6, 0, 0);
    add(1, 1, 7, 0, 0); add(3, 1, 8, 0, 0); add(5, 1, 1, 0, 1);
    add(0, 1, 2, 0, 0); add(9, 1, 0, 0, 1);

    reset         = 1'b0;
    digit_in      = '0;
    digit_valid   = 1'b0;
    s_digit_in    = '0;
    s_digit_valid = 1'b0;
    m_idx = '0; m_mc = '0; m_ec = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_exp_idx", int'(exp_idx), 0);
    chk("rst_id_ok", int'(id_ok), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    chk("rst_match_count", int'(match_count), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_exp_digit", int'(exp_digit), 5);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      apply(vecs[i].d, vecs[i].v, vecs[i].idx, vecs[i].ok, vecs[i].err);

    // two IDs with random idle gaps
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 9; k++) begin
        int unsigned gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < int'(gap); g++)
          apply(4'($urandom_range(0, 9)), 1'b0, 4'(k), 1'b0, 1'b0);
        apply(ref_seq[k], 1'b1, 4'((k + 1) % 9), k == 8, 1'b0);
      end
    end

    // asynchronous reset mid-sequence
    for (int k = 0; k < 4; k++)
      apply(ref_seq[k], 1'b1, 4'(k + 1), 1'b0, 1'b0);
    @(negedge clk);
    digit_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_exp_idx", int'(exp_idx), 0);
    chk("async_id_ok", int'(id_ok), 0);
    chk("async_seq_err", int'(seq_err), 0);
    chk("async_match_count", int'(match_count), 0);
    chk("async_err_count", int'(err_count), 0);
    m_idx = '0; m_mc = '0; m_ec = '0;
    @(negedge clk);
    reset = 1'b1;
    apply_id();

    // saturation on the CNT_W=4 instance: 17 IDs -> 15
    for (int n = 1; n <= 17; n++) begin
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        s_digit_in    = ref_seq[k];
        s_digit_valid = 1'b1;
      end
      @(negedge clk);
      s_digit_valid = 1'b0;
      chk("sat_match_count", int'(s_match_count), (n > 15) ? 15 : n);
    end
    chk("sat_seq_err", int'(s_seq_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
